bw_io_ddr_vref_ctl: RTL
=======================

// Module: bw_io_ddr_vref_ctl
// PURPOSE
//  Sequential controller that drives the 3-bit select {a,b,c} into the DDR vref decode stage (7-bit thermometer -> vrefcode[7:0]).
//  Ramps the live select one code at a time toward a software target, holding SETTLE_CYC cycles per step so the analog vref never jumps.
//  Sits in the DDR pad-control cluster between the CSR write path and the vref decode logic.
// PARAMETERS
//  SETTLE_CYC  64    cycles held per code step before the next step; legal range 2..256.
//  RESET_CODE  3'd4  cur/tgt value after reset (midpoint vref).
// PORTS
//  clk       in   1  pad-control clock; single clock domain.
//  rst       in   1  reset: synchronous and active-high.
//  wr_en     in   1  one-cycle write strobe for target code; always accepted (no backpressure).
//  wr_data   in   3  new target code.
//  hold      in   1  freeze: settle counter and select do not change while 1.
//  a         out  1  cur_code[2] (MSB) to vref decode.
//  b         out  1  cur_code[1].
//  c         out  1  cur_code[0] (LSB).
//  cur_code  out  3  live select, status readback.
//  busy      out  1  (state!=IDLE) | (tgt!=cur_code); combinational from registers.
//  done      out  1  one-cycle registered pulse when cur_code reaches tgt.
// BEHAVIOUR
//  Reset (rst=1 at clk edge): cur_code=tgt=RESET_CODE, {a,b,c}=RESET_CODE, state=IDLE, cnt=0, done=0, busy=0.
//  {a,b,c} are flop outputs equal to cur_code; there is no combinational path from inputs.
//  tgt loads wr_data on any clk edge with wr_en=1, in any state; last write wins.
//  FSM states: IDLE, WAIT.
//   IDLE: if tgt!=cur_code -> WAIT, cnt<=SETTLE_CYC-1; else stay.
//   WAIT, hold=1: cnt, cur_code and state are frozen.
//   WAIT, hold=0, cnt!=0: cnt<=cnt-1.
//   WAIT, hold=0, cnt==0: step cur_code by +1 if tgt>cur_code, by -1 if tgt<cur_code.
//    - If post-step cur_code==tgt -> IDLE, done<=1 on the next edge.
//    - Else cnt<=SETTLE_CYC-1 and stay in WAIT.
//    - If tgt==cur_code at cnt==0 (retargeted mid-wait): no step, -> IDLE, done pulses.
//  Latency: wr_en at edge E0.
//   - IDLE sees the mismatch in cycle E0+1.
//   - First step lands at edge E0+1+SETTLE_CYC.
//   - Each further step takes SETTLE_CYC cycles.
//   - done is high the cycle after the final step.
//  Step is exactly ±1 with 3-bit compare. cur_code never wraps: the 7->0 and 0->7 transitions are impossible.
//  wr_en and step on the same edge: the step uses the old tgt; the new tgt is evaluated from the next cycle.
//  Write of tgt==cur_code while IDLE: no activity, no done pulse.
//  rst mid-ramp overrides everything, including hold.
//  done is never asserted in the same cycle as rst or in the cycle after rst.
//  hold in IDLE has no effect on tgt capture; the IDLE->WAIT transition still occurs.
// CONFIGURATION
//  BW_IO_DDR_VREF_BYPASS_EN defined: adds input byp_en (1 bit).
//   - With byp_en=1, wr_en loads cur_code and tgt from wr_data on the same edge (a,b,c change one cycle after the write).
//   - state is forced to IDLE, cnt=0, done is not pulsed, and hold is ignored.
//   - byp_en 1->0 resumes normal ramping from the current values.
//  Macro undefined: port byp_en is absent and the block ramps only.
// STRUCTURE
//  Package bw_io_ddr_vref_pkg holds:
//   - typedef vref_code_t (logic [2:0]);
//   - enum vref_state_e {IDLE, WAIT};
//   - localparam VREF_CODE_MAX=3'd7.
//  cnt width is $clog2(SETTLE_CYC), computed locally.
//  One sub-module: bw_io_ddr_vref_settle_tmr (down-counter with load, hold and zero flag). The FSM and code regs stay in the top level.
// TESTING
//  Run all tests with SETTLE_CYC=4.
//  1. Reset: rst high 2 cycles -> {a,b,c}=3'b100, cur_code=4, busy=0, done=0.
//  2. Up-ramp: from 4, write 7 -> steps at edges +5, +9, +13 to 5, 6, 7; done one cycle after 7; busy drops with done.
//  3. Down-ramp with retarget: from 4, write 0; after the first step (3), write 3 -> no further step, IDLE, single done pulse, cur_code=3.
//  4. Hold: ramp 4->6, assert hold 10 cycles mid-WAIT -> cur_code and cnt frozen; step lands 10 cycles late; no skipped or extra steps.
//  5. Reset mid-ramp: ramp 1->7 interrupted at cur_code=3 by rst -> cur_code=tgt=4 next cycle; no done pulse.
//  6. BYPASS_EN build: byp_en=1, write 6 from 4 -> cur_code=6 one cycle later, done stays 0; then byp_en=0, write 4 -> normal 2-step ramp.

Source files
------------

// File: rtl/bw_io_ddr_vref_pkg.sv
// Shared types for the DDR vref select ramp controller.
// Code type, FSM states and the code ceiling used by the step helper.
package bw_io_ddr_vref_pkg;

  typedef logic [2:0] vref_code_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } vref_state_e;

  localparam vref_code_t VREF_CODE_MAX = 3'd7;

  // One code toward tgt, saturating at both ends so the select never wraps.
  function automatic vref_code_t step_toward(input vref_code_t cur, input vref_code_t tgt);
    vref_code_t nxt;
    nxt = cur;
    if ((tgt > cur) && (cur != VREF_CODE_MAX)) begin
      nxt = cur + 3'd1;
    end else if ((tgt < cur) && (cur != 3'd0)) begin
      nxt = cur - 3'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bw_io_ddr_vref_settle_tmr.sv
// Settle down-counter: clear > load > hold > decrement; stops at zero.
// zero is combinational from the count register.
module bw_io_ddr_vref_settle_tmr #(
  parameter int unsigned CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          hold,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (!hold && en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/bw_io_ddr_vref_ctl.sv
// Ramps the DDR vref select {a,b,c} one code per SETTLE_CYC cycles toward a written target.
// Optional macro BW_IO_DDR_VREF_BYPASS_EN adds byp_en for direct code loads.
module bw_io_ddr_vref_ctl
  import bw_io_ddr_vref_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 64,
  parameter vref_code_t  RESET_CODE = 3'd4
) (
  input  logic       clk,
  input  logic       rst,
`ifdef BW_IO_DDR_VREF_BYPASS_EN
  input  logic       byp_en,
`endif
  input  logic       wr_en,
  input  logic [2:0] wr_data,
  input  logic       hold,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic [2:0] cur_code,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(SETTLE_CYC - 1);

  vref_state_e state_q, state_d;
  vref_code_t  cur_q, cur_d, tgt_q, nxt_code;
  logic        done_q, done_d;
  logic        tmr_clr, tmr_load, tmr_zero;
  logic [CW-1:0] tmr_cnt;
  logic        byp;

`ifdef BW_IO_DDR_VREF_BYPASS_EN
  assign byp = byp_en;
`else
  assign byp = 1'b0;
`endif

  bw_io_ddr_vref_settle_tmr #(.CW(CW)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .load_val (CNT_RELOAD),
    .hold     (hold),
    .en       (state_q == WAIT),
    .cnt      (tmr_cnt),
    .zero     (tmr_zero)
  );

  assign nxt_code = step_toward(cur_q, tgt_q);

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    done_d   = 1'b0;
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    if (state_q == IDLE) begin
      if (tgt_q != cur_q) begin
        state_d  = WAIT;
        tmr_load = 1'b1;
      end
    end else if (!hold && tmr_zero) begin
      // A mid-wait retarget onto cur_q yields nxt_code == cur_q and ends here.
      cur_d = nxt_code;
      if (nxt_code == tgt_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        tmr_load = 1'b1;
      end
    end
    if (byp) begin
      state_d  = IDLE;
      done_d   = 1'b0;
      tmr_clr  = 1'b1;
      tmr_load = 1'b0;
      cur_d    = wr_en ? wr_data : cur_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= RESET_CODE;
      tgt_q   <= RESET_CODE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      done_q  <= done_d;
      if (wr_en) begin
        tgt_q <= wr_data;
      end
    end
  end

  assign a        = cur_q[2];
  assign b        = cur_q[1];
  assign c        = cur_q[0];
  assign cur_code = cur_q;
  assign busy     = (state_q != IDLE) | (tgt_q != cur_q);
  assign done     = done_q;

endmodule
